// File: rtl/sdm_mod_param_if.sv
// Sample handshake between the upstream sample source and the modulator.
// The master drives a signed sample with a valid strobe; the slave answers with ready.
interface sdm_mod_param_if #(
    parameter int DATA_W = 16
);
    logic signed [DATA_W-1:0] DATAWORD_IN;
    logic                     IN_VALID;
    logic                     IN_READY;

    modport master (output DATAWORD_IN, output IN_VALID, input IN_READY);
    modport slave  (input DATAWORD_IN, input IN_VALID, output IN_READY);
endinterface

// File: rtl/sdm_mod_param.sv
// Single-bit sigma-delta modulator, first or second order selected when leaving IDLE.
// Integrators carry GUARD extra bits and saturate; one sample is requested per OSR ticks.
module sdm_mod_param #(
    parameter int DATA_W = 16,
    parameter int OSR    = 64,
    parameter int GUARD  = 3
) (
    input  logic           CLOCK,
    input  logic           RESET,
    sdm_mod_param_if.slave i_smp,
    input  logic           ENABLE,
    input  logic           ORDER_SEL,
    input  logic           CLEAR_FLAGS,
    output logic           DATA_OUT,
    output logic           BIT_VALID,
    output logic           UNDERRUN,
    output logic           SAT_FLAG
);
    // state  | meaning
    // S_IDLE | waiting for enable and a first sample; integrators at 0
    // S_RUN  | one modulator tick per cycle, new sample requested every OSR ticks
    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam int ACC_W = DATA_W + GUARD;
    localparam int SUM_W = ACC_W + 2;
    localparam int CNT_W = $clog2(OSR);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);
    localparam logic signed [SUM_W-1:0] FB_POS  = {{(SUM_W-DATA_W){1'b0}}, 1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] ACC_MIN = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

    function automatic logic signed [ACC_W-1:0] f_clamp(input logic signed [SUM_W-1:0] v);
        if (v > ACC_MAX)      return ACC_MAX[ACC_W-1:0];
        else if (v < ACC_MIN) return ACC_MIN[ACC_W-1:0];
        else                  return v[ACC_W-1:0];
    endfunction

    function automatic logic f_clamps(input logic signed [SUM_W-1:0] v);
        return (v > ACC_MAX) || (v < ACC_MIN);
    endfunction

    state_t                   r_state, w_state_nxt;
    logic [CNT_W-1:0]         r_cnt, w_cnt_nxt;
    logic signed [DATA_W-1:0] r_sample, w_sample_nxt;
    logic                     r_order, w_order_nxt;
    logic signed [ACC_W-1:0]  r_i1, w_i1_nxt;
    logic signed [ACC_W-1:0]  r_i2, w_i2_nxt;
    logic                     r_data_out, w_data_out_nxt;
    logic                     r_bit_valid, w_bit_valid_nxt;
    logic                     r_underrun, w_underrun_set;
    logic                     r_sat, w_sat_set;
    logic                     w_in_ready;

    logic signed [SUM_W-1:0]  w_x_ext, w_fb, w_sum1, w_sum2;
    logic signed [ACC_W-1:0]  w_i1n, w_i2n;

    // Sums are formed two bits wider than the integrators so the clamp sees the true value.
    assign w_x_ext = {{(SUM_W-DATA_W){r_sample[DATA_W-1]}}, r_sample};
    assign w_fb    = r_data_out ? FB_POS : -FB_POS;
    assign w_sum1  = {{2{r_i1[ACC_W-1]}}, r_i1} + w_x_ext - w_fb;
    assign w_i1n   = f_clamp(w_sum1);
    assign w_sum2  = {{2{r_i2[ACC_W-1]}}, r_i2} + {{2{w_i1n[ACC_W-1]}}, w_i1n} - w_fb;
    assign w_i2n   = f_clamp(w_sum2);

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_sample_nxt    = r_sample;
        w_order_nxt     = r_order;
        w_i1_nxt        = r_i1;
        w_i2_nxt        = r_i2;
        w_data_out_nxt  = r_data_out;
        w_bit_valid_nxt = r_bit_valid;
        w_underrun_set  = 1'b0;
        w_sat_set       = 1'b0;
        w_in_ready      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready      = ENABLE;
                w_bit_valid_nxt = 1'b0;
                if (i_smp.IN_VALID && ENABLE) begin
                    w_sample_nxt = i_smp.DATAWORD_IN;
                    w_order_nxt  = ORDER_SEL;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = S_RUN;
                end
            end
            S_RUN: begin
                if (!ENABLE) begin
                    w_state_nxt     = S_IDLE;
                    w_cnt_nxt       = '0;
                    w_i1_nxt        = '0;
                    w_i2_nxt        = '0;
                    w_data_out_nxt  = 1'b0;
                    w_bit_valid_nxt = 1'b0;
                end else begin
                    w_in_ready      = (r_cnt == CNT_LAST);
                    w_bit_valid_nxt = 1'b1;
                    w_i1_nxt        = w_i1n;
                    if (r_order) begin
                        w_i2_nxt       = w_i2n;
                        w_data_out_nxt = ~w_i2n[ACC_W-1];
                        w_sat_set      = f_clamps(w_sum1) || f_clamps(w_sum2);
                    end else begin
                        w_i2_nxt       = '0;
                        w_data_out_nxt = ~w_i1n[ACC_W-1];
                        w_sat_set      = f_clamps(w_sum1);
                    end
                    if (w_in_ready) begin
                        w_cnt_nxt = '0;
                        if (i_smp.IN_VALID) w_sample_nxt = i_smp.DATAWORD_IN;
                        else                w_underrun_set = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_sample    <= '0;
            r_order     <= 1'b0;
            r_i1        <= '0;
            r_i2        <= '0;
            r_data_out  <= 1'b0;
            r_bit_valid <= 1'b0;
            r_underrun  <= 1'b0;
            r_sat       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sample    <= w_sample_nxt;
            r_order     <= w_order_nxt;
            r_i1        <= w_i1_nxt;
            r_i2        <= w_i2_nxt;
            r_data_out  <= w_data_out_nxt;
            r_bit_valid <= w_bit_valid_nxt;
            // A new event outranks a simultaneous clear.
            r_underrun  <= (r_underrun && !CLEAR_FLAGS) || w_underrun_set;
            r_sat       <= (r_sat && !CLEAR_FLAGS) || w_sat_set;
        end
    end

    assign i_smp.IN_READY = w_in_ready;
    assign DATA_OUT       = r_data_out;
    assign BIT_VALID      = r_bit_valid;
    assign UNDERRUN       = r_underrun;
    assign SAT_FLAG       = r_sat;
endmodule

// File: tb/tb_sdm_mod_param.sv
// Directed bench for sdm_mod_param: one OSR=4 and one OSR=64 instance, both 16-bit, GUARD=3.
// Expected bit patterns and integrator values are worked out by hand from the loop equations.
module tb_sdm_mod_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst4_b, en4, ord4, clr4, dout4, bv4, und4, sat4;
    logic rst64_b, en64, ord64, clr64, dout64, bv64, und64, sat64;

    sdm_mod_param_if #(.DATA_W(16)) if4 ();
    sdm_mod_param_if #(.DATA_W(16)) if64 ();

    sdm_mod_param #(.DATA_W(16), .OSR(4), .GUARD(3)) u4 (
        .CLOCK(clk), .RESET(rst4_b), .i_smp(if4), .ENABLE(en4), .ORDER_SEL(ord4),
        .CLEAR_FLAGS(clr4), .DATA_OUT(dout4), .BIT_VALID(bv4), .UNDERRUN(und4), .SAT_FLAG(sat4)
    );

    sdm_mod_param #(.DATA_W(16), .OSR(64), .GUARD(3)) u64 (
        .CLOCK(clk), .RESET(rst64_b), .i_smp(if64), .ENABLE(en64), .ORDER_SEL(ord64),
        .CLEAR_FLAGS(clr64), .DATA_OUT(dout64), .BIT_VALID(bv64), .UNDERRUN(und64), .SAT_FLAG(sat64)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_o1 [8];
    int smp [4];

    initial begin
        exp_o1 = '{1, 1, 0, 1, 0, 1, 0, 1};
        smp    = '{100, 200, 300, 400};
        rst4_b = 1'b0; en4 = 1'b0; ord4 = 1'b0; clr4 = 1'b0;
        rst64_b = 1'b0; en64 = 1'b0; ord64 = 1'b0; clr64 = 1'b0;
        if4.DATAWORD_IN = '0;  if4.IN_VALID = 1'b0;
        if64.DATAWORD_IN = '0; if64.IN_VALID = 1'b0;
        tick();
        tick();

        // reset state
        chk("rst_dout", dout64, 0);
        chk("rst_bv", bv64, 0);
        chk("rst_und", und64, 0);
        chk("rst_sat", sat64, 0);
        chk("rst_i1", u64.r_i1, 0);
        rst4_b = 1'b1; rst64_b = 1'b1;
        tick();
        chk("idle_ready_off", if64.IN_READY, 0);
        en64 = 1'b1;
        #1;
        chk("idle_ready_on", if64.IN_READY, 1);

        // order 1, x = 0 on OSR=64
        ord64 = 1'b0; if64.DATAWORD_IN = 16'sd0; if64.IN_VALID = 1'b1;
        tick();
        chk("o1_ready_run", if64.IN_READY, 0);
        chk("o1_bv_first", bv64, 0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("o1_dout", dout64, exp_o1[k]);
            chk("o1_bv", bv64, 1);
        end
        en64 = 1'b0;
        tick();
        chk("o1_stop_dout", dout64, 0);
        chk("o1_stop_bv", bv64, 0);

        // order 2 saturation with full-scale negative input
        ord64 = 1'b1; en64 = 1'b1; if64.DATAWORD_IN = -16'sd32768;
        tick();
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk("o2_dout", dout64, (k == 1) ? 1 : 0);
            if (k == 8) begin
                chk("o2_i2_limit", u64.r_i2, -262144);
                chk("o2_sat_t8", sat64, 0);
            end
            if (k == 9) begin
                chk("o2_sat_t9", sat64, 1);
                chk("o2_i2_clamped", u64.r_i2, -262144);
                chk("o2_i1", u64.r_i1, -65536);
            end
        end

        // ENABLE drop with ORDER_SEL toggled and a sample offered in the same cycle
        en64 = 1'b0; ord64 = 1'b0; if64.DATAWORD_IN = 16'sd5;
        #1;
        chk("drop_ready", if64.IN_READY, 0);
        tick();
        chk("drop_dout", dout64, 0);
        chk("drop_bv", bv64, 0);
        chk("drop_sat_kept", sat64, 1);
        chk("drop_no_accept", u64.r_sample, -32768);
        chk("drop_i2", u64.r_i2, 0);
        en64 = 1'b1; if64.DATAWORD_IN = 16'sd0;
        #1;
        chk("reidle_ready", if64.IN_READY, 1);
        tick();
        chk("reacc_order", u64.r_order, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("reacc_dout", dout64, exp_o1[k]);
        end
        clr64 = 1'b1;
        tick();
        chk("clr_sat", sat64, 0);
        clr64 = 1'b0; en64 = 1'b0; if64.IN_VALID = 1'b0;

        // handshake on OSR=4, valid held high
        en4 = 1'b1; ord4 = 1'b0; if4.DATAWORD_IN = 16'sd100; if4.IN_VALID = 1'b1;
        #1;
        chk("hs_idle_ready", if4.IN_READY, 1);
        tick();
        if4.DATAWORD_IN = 16'sd200;
        for (int s = 0; s < 2; s++) begin
            for (int c = 0; c < 4; c++) begin
                chk("hs_ready", if4.IN_READY, (c == 3) ? 1 : 0);
                chk("hs_sample", u4.r_sample, smp[s]);
                tick();
                if (c == 3) if4.DATAWORD_IN = 16'(smp[s + 2]);
            end
        end
        chk("hs_sample_last", u4.r_sample, 300);
        chk("hs_und", und4, 0);

        // underrun: valid dropped at a request
        tick(); tick(); tick();
        chk("ur_req", if4.IN_READY, 1);
        if4.IN_VALID = 1'b0; if4.DATAWORD_IN = 16'sd999;
        tick();
        chk("ur_set", und4, 1);
        chk("ur_keep_sample", u4.r_sample, 300);
        chk("ur_wrap", if4.IN_READY, 0);
        tick(); tick(); tick();
        chk("ur_req2", if4.IN_READY, 1);
        clr4 = 1'b1;
        tick();
        chk("ur_set_beats_clr", und4, 1);
        tick();
        chk("ur_clr", und4, 0);
        clr4 = 1'b0;
        tick(); tick(); tick();
        chk("ur_set_again", und4, 1);
        chk("ur_bv_before_rst", bv4, 1);

        // asynchronous reset mid-cycle while running
        #4;
        rst4_b = 1'b0;
        #1;
        chk("arst_dout", dout4, 0);
        chk("arst_bv", bv4, 0);
        chk("arst_und", und4, 0);
        chk("arst_sat", sat4, 0);
        chk("arst_i1", u4.r_i1, 0);
        chk("arst_cnt", u4.r_cnt, 0);
        tick();
        rst4_b = 1'b1;
        tick();
        chk("arst_ready_en", if4.IN_READY, 1);
        en4 = 1'b0;
        #1;
        chk("arst_ready_dis", if4.IN_READY, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
